// File: rtl/power_isa_pkg.sv
// Shared Power ISA constants: register/immediate widths, DS-form load/store
// micro-op encodings and functional-unit routing codes.
package power_isa_pkg;

  localparam int unsigned REG_WIDTH  = 5;
  localparam int unsigned IMM_WIDTH  = 14;
  localparam int unsigned DATA_WIDTH = 64;

  // DS-form load/store micro-ops; encodings 6 and 7 are reserved.
  typedef enum logic [2:0] {
    OP_LD   = 3'd0,
    OP_LDU  = 3'd1,
    OP_LWA  = 3'd2,
    OP_STD  = 3'd3,
    OP_STDU = 3'd4,
    OP_STQ  = 3'd5
  } ldst_op_e;

  // Functional-unit codes. Only the first four fit the 2-bit decode routing
  // field; trap ops reach their unit over a different path.
  localparam int unsigned FU_FX     = 0;
  localparam int unsigned FU_FP     = 1;
  localparam int unsigned FU_LDST   = 2;
  localparam int unsigned FU_BRANCH = 3;
  localparam int unsigned FU_TRAP   = 4;

  // Update forms write the effective address back to RA.
  function automatic logic is_update(input logic [2:0] op);
    return (op == OP_LDU) || (op == OP_STDU);
  endfunction

endpackage

// File: rtl/ds_ldst_issue_queue_if.sv
// Decode-to-queue and queue-to-LSU signal bundle. The master side is the
// environment (decode plus LSU); the slave side is the issue queue.
interface ds_ldst_issue_queue_if
  import power_isa_pkg::*;
#(
  parameter int regWidth  = REG_WIDTH,
  parameter int immWidth  = IMM_WIDTH,
  parameter int dataWidth = DATA_WIDTH,
  parameter int depth     = 4
);

  // Decode side
  logic                      enable_i;
  logic [2:0]                op_i;
  logic [regWidth-1:0]       reg1_i;
  logic [regWidth-1:0]       reg2_i;
  logic                      reg2ValOrZero_i;
  logic [immWidth-1:0]       imm_i;
  logic [1:0]                functionalUnitCode_i;
  logic                      stall_o;

  // LSU side
  logic                      valid_o;
  logic                      ready_i;
  logic [2:0]                op_o;
  logic [regWidth-1:0]       reg1_o;
  logic [regWidth-1:0]       reg2_o;
  logic                      raZero_o;
  logic [dataWidth-1:0]      disp_o;
  logic                      update_o;
  logic                      illegal_o;
  logic [$clog2(depth):0]    count_o;

  modport master (
    output enable_i, op_i, reg1_i, reg2_i, reg2ValOrZero_i, imm_i,
           functionalUnitCode_i, ready_i,
    input  stall_o, valid_o, op_o, reg1_o, reg2_o, raZero_o, disp_o,
           update_o, illegal_o, count_o
  );

  modport slave (
    input  enable_i, op_i, reg1_i, reg2_i, reg2ValOrZero_i, imm_i,
           functionalUnitCode_i, ready_i,
    output stall_o, valid_o, op_o, reg1_o, reg2_o, raZero_o, disp_o,
           update_o, illegal_o, count_o
  );

endinterface

// File: rtl/ds_ldst_issue_queue_sync_fifo.sv
// Generic synchronous FIFO: register-array storage, read/write pointers that
// wrap modulo DEPTH, and an occupancy counter. Pushes while full and pops
// while empty are ignored. Head data is a combinational read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AddrWidth = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [AddrWidth-1:0] wr_ptr;
  logic [AddrWidth-1:0] rd_ptr;
  logic [AddrWidth:0]   count_q;
  logic                 push_en;
  logic                 pop_en;

  assign full    = (count_q == (AddrWidth+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !full && !reset_i;
  assign pop_en  = pop && !empty && !reset_i;
  assign rdata   = mem[rd_ptr];
  assign count   = count_q;

  // Entry storage write.
  // NOTE: the array has no reset; pointers and count alone decide which
  // entries are live, so clearing the data would only cost logic.
  always_ff @(posedge clock_i) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy update; power-of-two depth makes the wrap free.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ds_ldst_issue_queue.sv
// DS-form load/store issue queue: forms the scaled sign-extended
// displacement, the RA-literal-zero flag, the update flag and the
// invalid-form flag at push time, then buffers the packed entry in a FIFO
// feeding the LSU with valid/ready, and stalls decode when full.
module ds_ldst_issue_queue
  import power_isa_pkg::*;
#(
  parameter int regWidth     = REG_WIDTH,
  parameter int immWidth     = IMM_WIDTH,
  parameter int dataWidth    = DATA_WIDTH,
  parameter int depth        = 4,
  parameter int LdStUnitCode = FU_LDST
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  ds_ldst_issue_queue_if.slave  bus
);

  typedef struct packed {
    logic [2:0]           op;
    logic [regWidth-1:0]  reg1;
    logic [regWidth-1:0]  reg2;
    logic                 ra_zero;
    logic [dataWidth-1:0] disp;
    logic                 update;
    logic                 illegal;
  } entry_t;

  entry_t                  push_entry;
  entry_t                  head_entry;
  logic                    push_req;
  logic                    pop_req;
  logic                    full;
  logic                    empty;
  logic [$clog2(depth):0]  count;

  // Field formation for the incoming micro-op.
  // NOTE: every field gets a default before the real assignments so this
  // block can never infer a latch if a branch is added later.
  always_comb begin
    push_entry         = '0;
    push_entry.op      = bus.op_i;
    push_entry.reg1    = bus.reg1_i;
    push_entry.reg2    = bus.reg2_i;
    push_entry.ra_zero = bus.reg2ValOrZero_i && (bus.reg2_i == '0);
    // DS field scaled by 4, sign taken from its most significant bit.
    push_entry.disp    = {{(dataWidth-immWidth-2){bus.imm_i[immWidth-1]}},
                          bus.imm_i, 2'b00};
    push_entry.update  = is_update(bus.op_i);
    // The STQ even-RS rule looks at the ISA's last RS bit, i.e. our LSB.
    push_entry.illegal = (push_entry.update && (bus.reg2_i == '0))
                       || ((bus.op_i == OP_LDU) && (bus.reg2_i == bus.reg1_i))
                       || ((bus.op_i == OP_STQ) && bus.reg1_i[0])
                       || (bus.op_i[2:1] == 2'b11);
  end

  // Other-unit traffic is ignored without stalling; the FIFO itself
  // refuses a push while full, even if the head pops in the same cycle.
  assign push_req = bus.enable_i && (bus.functionalUnitCode_i == 2'(LdStUnitCode));
  assign pop_req  = !empty && bus.ready_i;

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (depth)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push    (push_req),
    .pop     (pop_req),
    .wdata   (push_entry),
    .rdata   (head_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign bus.stall_o   = full;
  assign bus.valid_o   = !empty;
  assign bus.op_o      = head_entry.op;
  assign bus.reg1_o    = head_entry.reg1;
  assign bus.reg2_o    = head_entry.reg2;
  assign bus.raZero_o  = head_entry.ra_zero;
  assign bus.disp_o    = head_entry.disp;
  assign bus.update_o  = head_entry.update;
  assign bus.illegal_o = head_entry.illegal;
  assign bus.count_o   = count;

endmodule

// File: tb/tb_ds_ldst_issue_queue.sv
// Directed self-checking bench for ds_ldst_issue_queue. Inputs change 1ns
// after the rising edge and outputs are sampled there as well.
module tb_ds_ldst_issue_queue;
  import power_isa_pkg::*;

  logic clock_i = 1'b0;
  logic reset_i;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clock_i = ~clock_i;

  ds_ldst_issue_queue_if bus ();

  ds_ldst_issue_queue dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic idle();
    bus.enable_i             = 1'b0;
    bus.op_i                 = 3'd0;
    bus.reg1_i               = 5'd0;
    bus.reg2_i               = 5'd0;
    bus.reg2ValOrZero_i      = 1'b0;
    bus.imm_i                = 14'd0;
    bus.functionalUnitCode_i = 2'd2;
  endtask

  task automatic set_push(input logic [2:0] op, input logic [4:0] r1,
                          input logic [4:0] r2, input logic z,
                          input logic [13:0] imm, input logic [1:0] fu);
    bus.enable_i             = 1'b1;
    bus.op_i                 = op;
    bus.reg1_i               = r1;
    bus.reg2_i               = r2;
    bus.reg2ValOrZero_i      = z;
    bus.imm_i                = imm;
    bus.functionalUnitCode_i = fu;
  endtask

  task automatic test_reset();
    idle();
    bus.ready_i = 1'b0;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.valid_o);
    end
    vectors++;
    if (bus.count_o !== 3'd0) begin
      miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count_o);
    end
    vectors++;
    if (bus.stall_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o);
    end
  endtask

  task automatic test_ld_basic();
    set_push(OP_LD, 5'd3, 5'd4, 1'b0, 14'h0001, 2'd2);
    // No bypass: the queue is still empty in the push cycle.
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++; $display("FAIL ld_no_bypass: got %b expected 0", bus.valid_o);
    end
    tick();
    idle();
    vectors++;
    if (bus.valid_o !== 1'b1) begin
      miscompares++; $display("FAIL ld_valid: got %b expected 1", bus.valid_o);
    end
    vectors++;
    if (bus.disp_o !== 64'h4) begin
      miscompares++; $display("FAIL ld_disp: got %h expected 4", bus.disp_o);
    end
    vectors++;
    if ({bus.raZero_o, bus.update_o, bus.illegal_o} !== 3'b000) begin
      miscompares++; $display("FAIL ld_flags: got %b expected 000",
                              {bus.raZero_o, bus.update_o, bus.illegal_o});
    end
    vectors++;
    if ({bus.op_o, bus.reg1_o, bus.reg2_o} !== {3'd0, 5'd3, 5'd4}) begin
      miscompares++; $display("FAIL ld_fields: got op %0d rt %0d ra %0d expected 0 3 4",
                              bus.op_o, bus.reg1_o, bus.reg2_o);
    end
    vectors++;
    if (bus.count_o !== 3'd1) begin
      miscompares++; $display("FAIL ld_count: got %0d expected 1", bus.count_o);
    end
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    vectors++;
    if ({bus.valid_o, bus.count_o} !== {1'b0, 3'd0}) begin
      miscompares++; $display("FAIL ld_pop: got valid %b count %0d expected 0 0",
                              bus.valid_o, bus.count_o);
    end
  endtask

  task automatic test_std_negative();
    set_push(OP_STD, 5'd9, 5'd0, 1'b1, 14'h3FFF, 2'd2);
    tick();
    // RA nonzero with the literal-zero hint must not set raZero.
    set_push(OP_LD, 5'd1, 5'd5, 1'b1, 14'h2000, 2'd2);
    tick();
    idle();
    vectors++;
    if (bus.disp_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      miscompares++; $display("FAIL std_disp: got %h expected fffffffffffffffc", bus.disp_o);
    end
    vectors++;
    if ({bus.raZero_o, bus.update_o, bus.illegal_o} !== 3'b100) begin
      miscompares++; $display("FAIL std_flags: got %b expected 100",
                              {bus.raZero_o, bus.update_o, bus.illegal_o});
    end
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    vectors++;
    if (bus.disp_o !== 64'hFFFF_FFFF_FFFF_8000) begin
      miscompares++; $display("FAIL ld_min_disp: got %h expected ffffffffffff8000", bus.disp_o);
    end
    vectors++;
    if (bus.raZero_o !== 1'b0) begin
      miscompares++; $display("FAIL ra_nonzero: got %b expected 0", bus.raZero_o);
    end
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
  endtask

  task automatic test_full_stall();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_push(OP_LD, 5'(10 + i), 5'd1, 1'b0, 14'(i), 2'd2);
      tick();
    end
    // Decode now presents the fifth op and holds it while stalled.
    set_push(OP_LD, 5'd14, 5'd1, 1'b0, 14'd4, 2'd2);
    vectors++;
    if ({bus.stall_o, bus.count_o} !== {1'b1, 3'd4}) begin
      miscompares++; $display("FAIL full_stall: got stall %b count %0d expected 1 4",
                              bus.stall_o, bus.count_o);
    end
    vectors++;
    if (bus.reg1_o !== 5'd10) begin
      miscompares++; $display("FAIL full_head0: got %0d expected 10", bus.reg1_o);
    end
    bus.ready_i = 1'b1;
    tick();
    vectors++;
    if ({bus.stall_o, bus.count_o, bus.reg1_o} !== {1'b0, 3'd3, 5'd11}) begin
      miscompares++; $display("FAIL full_pop_no_push: got stall %b count %0d head %0d expected 0 3 11",
                              bus.stall_o, bus.count_o, bus.reg1_o);
    end
    tick();
    idle();
    vectors++;
    if ({bus.count_o, bus.reg1_o} !== {3'd3, 5'd12}) begin
      miscompares++; $display("FAIL full_late_push: got count %0d head %0d expected 3 12",
                              bus.count_o, bus.reg1_o);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({bus.valid_o, bus.reg1_o, bus.count_o} !== {1'b1, 5'(12 + i), 3'(3 - i)}) begin
        miscompares++; $display("FAIL drain_%0d: got valid %b head %0d count %0d expected 1 %0d %0d",
                                i, bus.valid_o, bus.reg1_o, bus.count_o, 12 + i, 3 - i);
      end
      tick();
    end
    bus.ready_i = 1'b0;
    vectors++;
    if ({bus.valid_o, bus.count_o} !== {1'b0, 3'd0}) begin
      miscompares++; $display("FAIL drain_empty: got valid %b count %0d expected 0 0",
                              bus.valid_o, bus.count_o);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] exp_op  [4] = '{3'd1, 3'd4, 3'd5, 3'd1};
    logic [1:0] exp_flg [4] = '{2'b11, 2'b11, 2'b01, 2'b10}; // {update, illegal}
    bus.ready_i = 1'b0;
    set_push(OP_LDU,  5'd7, 5'd7, 1'b0, 14'd8, 2'd2); tick();
    set_push(OP_STDU, 5'd3, 5'd0, 1'b0, 14'd8, 2'd2); tick();
    set_push(OP_STQ,  5'd5, 5'd2, 1'b0, 14'd8, 2'd2); tick();
    set_push(OP_LDU,  5'd8, 5'd7, 1'b0, 14'd8, 2'd2); tick();
    idle();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({bus.valid_o, bus.op_o, bus.update_o, bus.illegal_o} !== {1'b1, exp_op[i], exp_flg[i]}) begin
        miscompares++; $display("FAIL illegal_%0d: got valid %b op %0d upd/ill %b%b expected 1 %0d %b",
                                i, bus.valid_o, bus.op_o, bus.update_o, bus.illegal_o,
                                exp_op[i], exp_flg[i]);
      end
      tick();
    end
    bus.ready_i = 1'b0;
    // Reserved encoding 6 and an even-RS STQ.
    set_push(3'd6, 5'd2, 5'd3, 1'b0, 14'd0, 2'd2); tick();
    set_push(OP_STQ, 5'd4, 5'd3, 1'b0, 14'd0, 2'd2); tick();
    idle();
    bus.ready_i = 1'b1;
    vectors++;
    if ({bus.update_o, bus.illegal_o} !== 2'b01) begin
      miscompares++; $display("FAIL reserved_op: got upd/ill %b%b expected 01",
                              bus.update_o, bus.illegal_o);
    end
    tick();
    vectors++;
    if (bus.illegal_o !== 1'b0) begin
      miscompares++; $display("FAIL stq_even: got %b expected 0", bus.illegal_o);
    end
    tick();
    bus.ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.ready_i = 1'b0;
    set_push(OP_LD, 5'd20, 5'd1, 1'b0, 14'd0, 2'd2); tick();
    set_push(OP_LD, 5'd21, 5'd1, 1'b0, 14'd0, 2'd2); tick();
    for (int i = 0; i < 6; i++) begin
      set_push(OP_STD, 5'(22 + i), 5'd1, 1'b0, 14'd0, 2'd2);
      bus.ready_i = 1'b1;
      vectors++;
      if (bus.reg1_o !== 5'(20 + i)) begin
        miscompares++; $display("FAIL b2b_head_%0d: got %0d expected %0d", i, bus.reg1_o, 20 + i);
      end
      tick();
      vectors++;
      if (bus.count_o !== 3'd2) begin
        miscompares++; $display("FAIL b2b_count_%0d: got %0d expected 2", i, bus.count_o);
      end
    end
    // Enabled op routed to another unit: ignored, no stall.
    bus.ready_i = 1'b0;
    set_push(OP_LD, 5'd30, 5'd1, 1'b0, 14'd0, 2'd0);
    tick();
    idle();
    vectors++;
    if ({bus.count_o, bus.stall_o} !== {3'd2, 1'b0}) begin
      miscompares++; $display("FAIL other_unit: got count %0d stall %b expected 2 0",
                              bus.count_o, bus.stall_o);
    end
    bus.ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.reg1_o !== 5'(26 + i)) begin
        miscompares++; $display("FAIL b2b_tail_%0d: got %0d expected %0d", i, bus.reg1_o, 26 + i);
      end
      tick();
    end
    bus.ready_i = 1'b0;
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++; $display("FAIL b2b_empty: got %b expected 0", bus.valid_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_push(OP_LD, 5'(16 + i), 5'd1, 1'b0, 14'd0, 2'd2);
      tick();
    end
    vectors++;
    if (bus.count_o !== 3'd3) begin
      miscompares++; $display("FAIL mid_pre_count: got %0d expected 3", bus.count_o);
    end
    set_push(OP_LD, 5'd19, 5'd1, 1'b0, 14'd0, 2'd2);
    bus.ready_i = 1'b1;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    idle();
    bus.ready_i = 1'b0;
    vectors++;
    if ({bus.valid_o, bus.count_o, bus.stall_o} !== {1'b0, 3'd0, 1'b0}) begin
      miscompares++; $display("FAIL mid_reset: got valid %b count %0d stall %b expected 0 0 0",
                              bus.valid_o, bus.count_o, bus.stall_o);
    end
    set_push(OP_STD, 5'd25, 5'd2, 1'b0, 14'd3, 2'd2);
    tick();
    idle();
    vectors++;
    if ({bus.count_o, bus.reg1_o, bus.disp_o} !== {3'd1, 5'd25, 64'hC}) begin
      miscompares++; $display("FAIL post_reset_push: got count %0d head %0d disp %h expected 1 25 c",
                              bus.count_o, bus.reg1_o, bus.disp_o);
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    bus.ready_i = 1'b0;
    idle();
    test_reset();
    test_ld_basic();
    test_std_negative();
    test_full_stall();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
